timetag_cmd_framer: RTL and testbench

TIMETAG_CMD_FRAMER -- requirements
Module: timetag_cmd_framer

---
 rtl/timetag_cmd_framer.sv | 173 +++++++++++++++++
 tb/tb_timetag_cmd_framer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timetag_cmd_framer.sv
// Byte-stream command framer: parses LEN/OPCODE/payload frames from the FX2 byte strobe
// and presents one decoded command at a time under a rdy/ack handshake, with sticky error flags.
module timetag_cmd_framer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned MAX_LEN = 5
) (
  input  logic        fx2_clk,
  input  logic        reset_n,
  input  logic        cmd_wr,
  input  logic [7:0]  cmd_in,
  output logic        cmd_rdy,
  input  logic        cmd_ack,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_data,
  output logic        err_len,
  output logic        err_ovf,
  output logic        err_timeout,
  input  logic        err_clr
);

  localparam logic [7:0] MaxLen   = 8'(MAX_LEN);
  localparam logic [7:0] GapLimit = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StOpcode,
    StPayload,
    StSkip,
    StPending
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;       // frame bytes still to be consumed
  logic [2:0]  idx_q, idx_d;       // payload byte index; bit 2 marks the 32-bit word as full
  logic [7:0]  gap_q, gap_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [31:0] data_q, data_d;
  logic        err_len_q, err_len_d;
  logic        err_ovf_q, err_ovf_d;
  logic        err_to_q, err_to_d;

  logic set_len, set_ovf, set_to;
  logic in_frame;

  assign in_frame = (state_q == StOpcode) || (state_q == StPayload) || (state_q == StSkip);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    gap_d    = 8'd0;
    rdy_d    = rdy_q;
    opcode_d = opcode_q;
    data_d   = data_q;
    set_len  = 1'b0;
    set_ovf  = 1'b0;
    set_to   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_wr && (cmd_in != 8'd0)) begin
          cnt_d = cmd_in;
          if (cmd_in <= MaxLen) begin
            state_d = StOpcode;
          end else begin
            set_len = 1'b1;
            state_d = StSkip;
          end
        end
      end

      StOpcode: begin
        if (cmd_wr) begin
          opcode_d = cmd_in;
          data_d   = 32'd0;
          idx_d    = 3'd0;
          cnt_d    = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = StPending;
            rdy_d   = 1'b1;
          end else begin
            state_d = StPayload;
          end
        end
      end

      StPayload: begin
        if (cmd_wr) begin
          if (!idx_q[2]) begin
            data_d[{idx_q[1:0], 3'b000} +: 8] = cmd_in;
            idx_d = idx_q + 3'd1;
          end
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = StPending;
            rdy_d   = 1'b1;
          end
        end
      end

      StSkip: begin
        if (cmd_wr) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = StIdle;
          end
        end
      end

      StPending: begin
        // Bytes arriving while a command is held are lost, including on the accepting cycle.
        set_ovf = cmd_wr;
        if (cmd_ack && rdy_q) begin
          rdy_d   = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (in_frame && !cmd_wr) begin
      if (gap_q == GapLimit) begin
        state_d = StIdle;
        set_to  = 1'b1;
      end else begin
        gap_d = gap_q + 8'd1;
      end
    end

    // A set event in the same cycle as err_clr leaves the flag set.
    err_len_d = set_len | (err_len_q & ~err_clr);
    err_ovf_d = set_ovf | (err_ovf_q & ~err_clr);
    err_to_d  = set_to  | (err_to_q  & ~err_clr);
  end

  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      idx_q     <= 3'd0;
      gap_q     <= 8'd0;
      rdy_q     <= 1'b0;
      opcode_q  <= 8'd0;
      data_q    <= 32'd0;
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      rdy_q     <= rdy_d;
      opcode_q  <= opcode_d;
      data_q    <= data_d;
      err_len_q <= err_len_d;
      err_ovf_q <= err_ovf_d;
      err_to_q  <= err_to_d;
    end
  end

  assign cmd_rdy     = rdy_q;
  assign cmd_opcode  = opcode_q;
  assign cmd_data    = data_q;
  assign err_len     = err_len_q;
  assign err_ovf     = err_ovf_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_timetag_cmd_framer.sv
// Bench for timetag_cmd_framer: frame-level queue model checked every cycle, directed
// scenarios with literal expectations, then randomized frames with random ack/clear.
module tb_timetag_cmd_framer;

  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned MAX_LEN = 5;

  logic        fx2_clk;
  logic        reset_n;
  logic        cmd_wr;
  logic [7:0]  cmd_in;
  logic        cmd_rdy;
  logic        cmd_ack;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        err_len;
  logic        err_ovf;
  logic        err_timeout;
  logic        err_clr;

  timetag_cmd_framer #(
    .TIMEOUT(TIMEOUT),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .fx2_clk    (fx2_clk),
    .reset_n    (reset_n),
    .cmd_wr     (cmd_wr),
    .cmd_in     (cmd_in),
    .cmd_rdy    (cmd_rdy),
    .cmd_ack    (cmd_ack),
    .cmd_opcode (cmd_opcode),
    .cmd_data   (cmd_data),
    .err_len    (err_len),
    .err_ovf    (err_ovf),
    .err_timeout(err_timeout),
    .err_clr    (err_clr)
  );

  initial fx2_clk = 1'b0;
  always #5 fx2_clk = ~fx2_clk;

  int total;
  int bad;

  // Reference model: collected frame bytes, the held command and the sticky flags.
  logic [7:0]  frame[$];
  logic        m_pending;
  logic [7:0]  m_op;
  logic [31:0] m_data;
  logic        m_elen;
  logic        m_eovf;
  logic        m_eto;
  int          m_gap;
  int          m_hs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    frame.delete();
    m_pending = 1'b0;
    m_op      = 8'h00;
    m_data    = 32'h0;
    m_elen    = 1'b0;
    m_eovf    = 1'b0;
    m_eto     = 1'b0;
    m_gap     = 0;
  endfunction

  function automatic void model_step();
    logic s_len, s_ovf, s_to;
    s_len = 1'b0;
    s_ovf = 1'b0;
    s_to  = 1'b0;
    if (m_pending) begin
      if (cmd_wr) s_ovf = 1'b1;
      if (cmd_ack) begin
        m_pending = 1'b0;
        m_hs++;
      end
    end else if (cmd_wr) begin
      m_gap = 0;
      frame.push_back(cmd_in);
      if (frame.size() == 1 && int'(frame[0]) > int'(MAX_LEN)) s_len = 1'b1;
      if (frame.size() == int'(frame[0]) + 1) begin
        if (frame[0] != 8'd0 && int'(frame[0]) <= int'(MAX_LEN)) begin
          m_pending = 1'b1;
          m_op      = frame[1];
          m_data    = 32'h0;
          for (int k = 2; k < frame.size(); k++) m_data = m_data | (32'(frame[k]) << (8 * (k - 2)));
        end
        frame.delete();
      end
    end else if (frame.size() > 0) begin
      m_gap++;
      if (m_gap == int'(TIMEOUT)) begin
        s_to = 1'b1;
        frame.delete();
        m_gap = 0;
      end
    end
    m_elen = s_len | (m_elen & ~err_clr);
    m_eovf = s_ovf | (m_eovf & ~err_clr);
    m_eto  = s_to  | (m_eto  & ~err_clr);
  endfunction

  task automatic model_loop();
    forever begin
      @(posedge fx2_clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge fx2_clk);
      if (reset_n) begin
        check("cyc_rdy", 32'(cmd_rdy), 32'(m_pending));
        check("cyc_err_len", 32'(err_len), 32'(m_elen));
        check("cyc_err_ovf", 32'(err_ovf), 32'(m_eovf));
        check("cyc_err_timeout", 32'(err_timeout), 32'(m_eto));
        if (m_pending) begin
          check("cyc_opcode", 32'(cmd_opcode), 32'(m_op));
          check("cyc_data", cmd_data, m_data);
        end
      end
    end
  endtask

  task automatic tick(input logic w, input logic [7:0] b, input logic ack, input logic clr);
    @(negedge fx2_clk);
    cmd_wr  = w;
    cmd_in  = b;
    cmd_ack = ack;
    err_clr = clr;
  endtask

  task automatic rtick(input logic w, input logic [7:0] b);
    tick(w, b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 60) == 0));
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle();
    tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int hs0;
    int r;
    int len;
    int g;
    total   = 0;
    bad     = 0;
    m_hs    = 0;
    reset_n = 1'b0;
    cmd_wr  = 1'b0;
    cmd_in  = 8'h00;
    cmd_ack = 1'b0;
    err_clr = 1'b0;
    model_reset();
    #1;
    check("reset_outputs", {cmd_rdy, err_len, err_ovf, err_timeout, cmd_opcode, cmd_data[19:0]},
          32'h0);
    check("reset_data", cmd_data, 32'h0);
    fork
      model_loop();
      compare_loop();
    join_none
    #21 reset_n = 1'b1;

    // Single command with 4-byte payload, little-endian.
    hs0 = m_hs;
    send(8'h05); send(8'h04); send(8'h00); send(8'h00); send(8'h00); send(8'h40);
    idle();
    check("s1_rdy", 32'(cmd_rdy), 32'h1);
    check("s1_opcode", 32'(cmd_opcode), 32'h04);
    check("s1_data", cmd_data, 32'h4000_0000);
    check("s1_model_data", m_data, 32'h4000_0000);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    check("s1_rdy_after_ack", 32'(cmd_rdy), 32'h0);
    check("s1_handshakes", 32'(m_hs - hs0), 32'h1);

    // Two frames with cmd_ack held high throughout.
    tick(1'b1, 8'h01, 1'b1, 1'b0);
    tick(1'b1, 8'h01, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("s2a_rdy", 32'(cmd_rdy), 32'h1);
    check("s2a_cmd", {16'h0, cmd_opcode, cmd_data[7:0]}, 32'h0000_0100);
    check("s2a_data", cmd_data, 32'h0);
    tick(1'b1, 8'h02, 1'b1, 1'b0);
    check("s2_rdy_gap", 32'(cmd_rdy), 32'h0);
    tick(1'b1, 8'h01, 1'b1, 1'b0);
    tick(1'b1, 8'h01, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("s2b_opcode", 32'(cmd_opcode), 32'h01);
    check("s2b_data", cmd_data, 32'h0000_0001);
    idle();
    check("s2_no_ovf", 32'(err_ovf), 32'h0);

    // Oversized LEN skipped entirely, then a valid opcode-only frame.
    send(8'h07); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'hEE); send(8'hFF);
    send(8'h11);
    send(8'h01); send(8'h02);
    idle();
    check("s3_err_len", 32'(err_len), 32'h1);
    check("s3_rdy", 32'(cmd_rdy), 32'h1);
    check("s3_opcode", 32'(cmd_opcode), 32'h02);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    check("s3_cleared", 32'(err_len), 32'h0);

    // Timeout boundary: 254 idle cycles are fine, the 255th abandons the frame.
    send(8'h03); send(8'h09);
    repeat (255) idle();
    check("s4_no_timeout_yet", 32'(err_timeout), 32'h0);
    idle();
    check("s4_timeout", 32'(err_timeout), 32'h1);
    check("s4_model_timeout", 32'(m_eto), 32'h1);
    check("s4_no_rdy", 32'(cmd_rdy), 32'h0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    check("s4_flags_clear", {29'h0, err_len, err_ovf, err_timeout}, 32'h0);

    // Byte dropped while a command is held.
    send(8'h01); send(8'h05);
    idle();
    check("s5_rdy", 32'(cmd_rdy), 32'h1);
    send(8'h33);
    idle();
    check("s5_err_ovf", 32'(err_ovf), 32'h1);
    check("s5_data_kept", cmd_data, 32'h0);
    check("s5_opcode_kept", 32'(cmd_opcode), 32'h05);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    check("s5_released", 32'(cmd_rdy), 32'h0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a payload.
    send(8'h09);
    repeat (9) send(8'h5A);
    send(8'h05); send(8'h07); send(8'h11); send(8'h22);
    #2;
    reset_n = 1'b0;
    cmd_wr  = 1'b0;
    #1;
    check("s6_reset_flags", {28'h0, cmd_rdy, err_len, err_ovf, err_timeout}, 32'h0);
    check("s6_reset_opcode", 32'(cmd_opcode), 32'h0);
    check("s6_reset_data", cmd_data, 32'h0);
    @(negedge fx2_clk);
    @(negedge fx2_clk);
    reset_n = 1'b1;
    send(8'h03); send(8'h0A); send(8'h34); send(8'h12);
    idle();
    check("s6_opcode", 32'(cmd_opcode), 32'h0A);
    check("s6_data", cmd_data, 32'h0000_1234);
    check("s6_no_flags", {29'h0, err_len, err_ovf, err_timeout}, 32'h0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized frames with random gaps, ack and err_clr.
    for (int f = 0; f < 400; f++) begin
      r = $urandom_range(0, 19);
      if (r < 2) len = 0;
      else if (r < 15) len = $urandom_range(1, 5);
      else if (r < 19) len = $urandom_range(6, 12);
      else len = 40;
      for (int i = 0; i <= len; i++) begin
        g = $urandom_range(0, 9);
        if ($urandom_range(0, 80) == 0) g = $urandom_range(250, 258);
        else if (g > 2) g = 0;
        repeat (g) rtick(1'b0, 8'h00);
        rtick(1'b1, (i == 0) ? 8'(len) : 8'($urandom));
      end
      repeat ($urandom_range(0, 3)) rtick(1'b0, 8'h00);
    end
    repeat (4) tick(1'b0, 8'h00, 1'b1, 1'b0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
